// File: rtl/rpi_serial_port_pkg.sv
// Purpose : shared constants and types for the RPi serial port block.
// Latency : n/a (package only).
// Backpressure: n/a.
package rpi_serial_port_pkg;

  // Register select codes carried on rpi_regsel
  localparam logic [1:0] REG_RD = 2'b00;
  localparam logic [1:0] REG_RC = 2'b01;
  localparam logic [1:0] REG_TD = 2'b10;
  localparam logic [1:0] REG_TC = 2'b11;

  localparam int         BYTE_BITS = 8;
  localparam int         CNT_W     = 4;
  // Count value at which the frame is one bit short of full
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BYTE_BITS - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,  // bit_cnt == 0
    ST_SHIFT = 2'd1,  // bit_cnt 1..7
    ST_FULL  = 2'd2,  // bit_cnt == 8, waiting for the latch strobe
    ST_ERR   = 2'd3   // overrun, frame will be discarded
  } rx_state_t;

endpackage

// File: rtl/rpi_serial_port_sync_edge.sv
// Purpose : N-stage synchronizer with rising-edge detect per bit.
// Latency : q is SYNC_STAGES clk after the pin; rise is combinational on q.
// Backpressure: none, free-running sampler.
// Ports: clk/rst_n; d = async inputs; q = synchronized levels;
//        rise = q high while the previous synchronized sample was low.
module sync_edge #(
  parameter int SYNC_STAGES = 2,
  parameter int WIDTH       = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] rise
);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] stg;
  logic [WIDTH-1:0]                  prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stg  <= '0;
      prev <= '0;
    end else begin
      stg  <= {stg[SYNC_STAGES-2:0], d};
      prev <= stg[SYNC_STAGES-1];
    end
  end

  assign q    = stg[SYNC_STAGES-1];
  assign rise = q & ~prev;

endmodule

// File: rtl/rpi_serial_port.sv
// Purpose : clocked RPi shift-register port; RX bytes into RD/RC, TX bytes out of TD/TC.
// Latency : SYNC_STAGES+1 clk pin edge to register update; rpi_sdata_in one clk later.
// Backpressure: none; the RPi paces everything, malformed RX frames raise frame_err.
// Ports: rpi_* = raw GPIO pins (async); td_in/tc_in = TI-side latches (sampled on sle);
//        rd_out/rc_out + rd_upd/rc_upd = bytes to the TI bus mux; frame_err = discarded frame.
module rpi_serial_port
  import rpi_serial_port_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rpi_sclk,
  input  logic       rpi_sle,
  input  logic [1:0] rpi_regsel,
  input  logic       rpi_sdata_out,
  output logic       rpi_sdata_in,
  input  logic [7:0] td_in,
  input  logic [7:0] tc_in,
  output logic [7:0] rd_out,
  output logic [7:0] rc_out,
  output logic       rd_upd,
  output logic       rc_upd,
  output logic       frame_err
);

  logic [1:0] ctl_rise, ctl_lvl_unused;
  logic [2:0] dat_q, dat_rise_unused;

  // Data and select use the same depth as the strobes so they line up with the edge
  sync_edge #(.SYNC_STAGES(SYNC_STAGES), .WIDTH(2)) u_ctl_sync (
    .clk(clk), .rst_n(rst_n), .d({rpi_sle, rpi_sclk}),
    .q(ctl_lvl_unused), .rise(ctl_rise)
  );

  sync_edge #(.SYNC_STAGES(SYNC_STAGES), .WIDTH(3)) u_dat_sync (
    .clk(clk), .rst_n(rst_n), .d({rpi_regsel, rpi_sdata_out}),
    .q(dat_q), .rise(dat_rise_unused)
  );

  logic       sclk_rise, sle_rise, sdata, is_rx, sel_chg;
  logic [1:0] sel, sel_prev;

  assign sclk_rise = ctl_rise[0];
  assign sle_rise  = ctl_rise[1];
  assign sdata     = dat_q[0];
  assign sel       = dat_q[2:1];
  assign is_rx     = (sel == REG_RD) || (sel == REG_RC);
  assign sel_chg   = (sel != sel_prev);

  rx_state_t        state, state_nxt;
  logic [CNT_W-1:0] bit_cnt, bit_cnt_nxt;
  logic [7:0]       rx_sr, rx_sr_nxt, tx_sr, tx_sr_nxt;
  logic [7:0]       rd_nxt, rc_nxt;
  logic             rd_upd_nxt, rc_upd_nxt, frame_err_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      bit_cnt      <= '0;
      rx_sr        <= '0;
      tx_sr        <= '0;
      sel_prev     <= REG_RD;
      rd_out       <= '0;
      rc_out       <= '0;
      rd_upd       <= 1'b0;
      rc_upd       <= 1'b0;
      frame_err    <= 1'b0;
      rpi_sdata_in <= 1'b0;
    end else begin
      state        <= state_nxt;
      bit_cnt      <= bit_cnt_nxt;
      rx_sr        <= rx_sr_nxt;
      tx_sr        <= tx_sr_nxt;
      sel_prev     <= sel;
      rd_out       <= rd_nxt;
      rc_out       <= rc_nxt;
      rd_upd       <= rd_upd_nxt;
      rc_upd       <= rc_upd_nxt;
      frame_err    <= frame_err_nxt;
      rpi_sdata_in <= tx_sr[7];
    end
  end

  always_comb begin
    state_nxt     = state;
    bit_cnt_nxt   = bit_cnt;
    rx_sr_nxt     = rx_sr;
    tx_sr_nxt     = tx_sr;
    rd_nxt        = rd_out;
    rc_nxt        = rc_out;
    rd_upd_nxt    = 1'b0;
    rc_upd_nxt    = 1'b0;
    frame_err_nxt = 1'b0;

    if (sel_chg) begin
      // A register switch abandons whatever RX frame was in progress
      state_nxt   = ST_IDLE;
      bit_cnt_nxt = '0;
    end else if (sle_rise) begin
      // sle has priority; a coincident sclk edge is dropped
      if (is_rx) begin
        if (state == ST_FULL) begin
          if (sel == REG_RD) begin
            rd_nxt     = rx_sr;
            rd_upd_nxt = 1'b1;
          end else begin
            rc_nxt     = rx_sr;
            rc_upd_nxt = 1'b1;
          end
        end else begin
          frame_err_nxt = 1'b1;
        end
        state_nxt   = ST_IDLE;
        bit_cnt_nxt = '0;
      end else begin
        tx_sr_nxt = (sel == REG_TC) ? tc_in : td_in;
      end
    end else if (sclk_rise) begin
      if (is_rx) begin
        unique case (state)
          ST_IDLE, ST_SHIFT: begin
            rx_sr_nxt   = {rx_sr[6:0], sdata};
            bit_cnt_nxt = bit_cnt + 1'b1;
            state_nxt   = (bit_cnt == CNT_LAST) ? ST_FULL : ST_SHIFT;
          end
          ST_FULL: state_nxt = ST_ERR;
          default: state_nxt = ST_ERR;
        endcase
      end else begin
        // Extra TX clocks simply shift zeros out
        tx_sr_nxt = {tx_sr[6:0], 1'b0};
      end
    end
  end

endmodule
